resp_misr_compactor: RTL and testbench

- Response compactor that sits directly downstream of the generated 32-output combinational benchmark stages.
- Accepts one 32-bit response vector per handshake and folds N of them into a 32-bit MISR signature.
- Compares the final signature against a golden value and reports pass/fail.
- Gives the benchmark flow a cycle-based BIST-style response analyser in place of per-vector comparison.

---
 rtl/resp_misr_compactor.sv | 97 +++++++++
 tb/tb_resp_misr_compactor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_misr_compactor.sv
// Response compactor: folds N handshaked response vectors into a MISR signature,
// then compares that signature against a golden value and reports pass/fail.
module resp_misr_compactor #(
    parameter int                WIDTH = 32,
    parameter int                CNT_W = 16,
    parameter logic [WIDTH-1:0]  POLY  = 32'h04C11DB7,
    parameter logic [WIDTH-1:0]  SEED  = 32'h00000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_lat;
    logic [WIDTH-1:0] sig_nxt;
    logic             start_ok;
    logic             accept;
    logic             last_beat;

    // Handshake: a beat transfers on any rising edge where resp_valid && resp_ready.
    // resp_ready is registered and only ever high in RUN; resp_valid may drop at will.
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign accept    = resp_valid && resp_ready;
    assign last_beat = accept && (count == (n_lat - ONE));
    assign sig_nxt   = {signature[WIDTH-2:0], 1'b0}
                     ^ (signature[WIDTH-1] ? POLY : '0)
                     ^ resp_data;

    assign busy      = (state == RUN) || (state == CHECK);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (num_patterns != '0) ? RUN : CHECK;
            RUN:        if (last_beat) state_nxt = CHECK;
            CHECK:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            signature  <= SEED;
            count      <= '0;
            n_lat      <= '0;
            resp_ready <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (start_ok) begin
            signature  <= SEED;
            count      <= '0;
            n_lat      <= num_patterns;
            resp_ready <= (num_patterns != '0);
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            if (accept) begin
                signature <= sig_nxt;
                count     <= count + ONE;
            end
            if (last_beat) begin
                resp_ready <= 1'b0;
            end
            // golden is only looked at during the single CHECK cycle
            if (state == CHECK) begin
                pass <= (signature == golden);
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Directed bench for resp_misr_compactor: a vector table of whole runs plus
// hand-written sequences for latency, gaps, mid-run reset and ignored inputs.
module tb_resp_misr_compactor;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_patterns;
    logic [31:0] golden;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] count;
    logic [1:0]  dbg_state;

    int cnt_cmp = 0;
    int cnt_err = 0;

    typedef struct {
        logic [15:0]      n;
        logic [31:0]      gold;
        logic [3:0][31:0] data;
        logic [31:0]      exp_sig;
        logic             exp_pass;
    } vec_t;

    vec_t vecs[6];

    resp_misr_compactor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .golden       (golden),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cnt_cmp++;
        if (act !== exp) begin
            cnt_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ d;
    endfunction

    // driver tasks
    task automatic start_run(input logic [15:0] n, input logic [31:0] g);
        start = 1'b1;
        num_patterns = n;
        golden = g;
        tick();
        start = 1'b0;
        chk("start_ready", resp_ready, (n != 0));
        chk("start_busy",  busy, 1);
        chk("start_done",  done, 0);
        chk("start_count", count, 0);
        chk("start_sig",   signature, 0);
    endtask

    task automatic send_beat(input logic [31:0] d);
        int w;
        resp_valid = 1'b1;
        resp_data  = d;
        w = 0;
        while (!resp_ready && w < 20) begin
            tick();
            w++;
        end
        chk("ready_wait", resp_ready, 1);
        if (resp_ready) tick();
        resp_valid = 1'b0;
        resp_data  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!done && w < 10) begin
            tick();
            w++;
        end
        chk("done_wait", done, 1);
    endtask

    initial begin
        logic [31:0] ref_sig;
        logic [31:0] beats[10];
        logic        vpat[6];
        logic [31:0] dpat[6];
        int          exp_cnt;

        // vector table: whole runs, back to back from DONE
        vecs[0] = '{n: 16'd1, gold: 32'h00000001, data: '{0, 0, 0, 32'h00000001},
                    exp_sig: 32'h00000001, exp_pass: 1'b1};
        vecs[1] = '{n: 16'd2, gold: 32'h04C11DB7, data: '{0, 0, 32'h00000000, 32'h80000000},
                    exp_sig: 32'h04C11DB7, exp_pass: 1'b1};
        vecs[2] = '{n: 16'd2, gold: 32'h00000000, data: '{0, 0, 32'h00000000, 32'h80000000},
                    exp_sig: 32'h04C11DB7, exp_pass: 1'b0};
        vecs[3] = '{n: 16'd3, gold: 32'hD6D475D5, data: '{0, 32'h00000000, 32'h12345678, 32'hFFFFFFFF},
                    exp_sig: 32'hD6D475D5, exp_pass: 1'b1};
        vecs[4] = '{n: 16'd0, gold: 32'h00000000, data: '{0, 0, 0, 0},
                    exp_sig: 32'h00000000, exp_pass: 1'b1};
        vecs[5] = '{n: 16'd0, gold: 32'h00000001, data: '{0, 0, 0, 0},
                    exp_sig: 32'h00000000, exp_pass: 1'b0};

        rst = 1'b1;
        start = 1'b0;
        num_patterns = '0;
        golden = '0;
        resp_valid = 1'b0;
        resp_data = '0;
        tick();
        tick();
        chk("rst_state", dbg_state, 0);
        chk("rst_sig",   signature, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", resp_ready, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_pass",  pass, 0);
        rst = 1'b0;

        // single beat, exact latency: CHECK right after the beat, done one edge later
        start_run(16'd1, 32'h00000001);
        send_beat(32'h00000001);
        chk("lat_state_check", dbg_state, 2);
        chk("lat_done_early",  done, 0);
        chk("lat_ready_off",   resp_ready, 0);
        chk("lat_sig",         signature, 32'h00000001);
        tick();
        chk("lat_done", done, 1);
        chk("lat_pass", pass, 1);
        chk("lat_busy", busy, 0);

        for (int v = 0; v < 6; v++) begin
            start_run(vecs[v].n, vecs[v].gold);
            for (int i = 0; i < 4; i++) begin
                if (i < int'(vecs[v].n)) send_beat(vecs[v].data[i]);
            end
            wait_done();
            chk($sformatf("vec%0d_sig", v),   signature, vecs[v].exp_sig);
            chk($sformatf("vec%0d_pass", v),  pass, vecs[v].exp_pass);
            chk($sformatf("vec%0d_count", v), count, vecs[v].n);
        end

        // n=0 timing: CHECK on the first edge after start, done on the second
        start_run(16'd0, 32'h00000000);
        chk("n0_state_check", dbg_state, 2);
        tick();
        chk("n0_done", done, 1);
        chk("n0_pass", pass, 1);

        // gapped valid 1,0,0,1,0,1 must equal the gap-free 3-beat result
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        dpat = '{32'hFFFFFFFF, 32'h5555AAAA, 32'h0F0F0F0F, 32'h12345678, 32'hCAFEF00D, 32'h00000000};
        start_run(16'd3, 32'hD6D475D5);
        exp_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            resp_valid = vpat[c];
            resp_data  = dpat[c];
            tick();
            if (vpat[c]) exp_cnt++;
            chk($sformatf("gap_count_c%0d", c), count, exp_cnt);
        end
        resp_valid = 1'b0;
        chk("gap_ready_off", resp_ready, 0);
        tick();
        chk("gap_done", done, 1);
        chk("gap_sig",  signature, 32'hD6D475D5);
        chk("gap_pass", pass, 1);

        // reset after 5 of 10 beats, then a fresh uninterrupted run
        ref_sig = 32'h0;
        for (int i = 0; i < 10; i++) begin
            beats[i] = 32'h9E3779B9 * (i + 1) ^ 32'h0000_00FF;
            ref_sig  = misr(ref_sig, beats[i]);
        end
        start_run(16'd10, ref_sig);
        for (int i = 0; i < 5; i++) send_beat(beats[i]);
        chk("mid_count", count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_state", dbg_state, 0);
        chk("mrst_sig",   signature, 0);
        chk("mrst_count", count, 0);
        chk("mrst_ready", resp_ready, 0);
        chk("mrst_busy",  busy, 0);
        start_run(16'd10, ref_sig);
        for (int i = 0; i < 10; i++) send_beat(beats[i]);
        wait_done();
        chk("rerun_sig",   signature, ref_sig);
        chk("rerun_pass",  pass, 1);
        chk("rerun_count", count, 10);

        // valid in IDLE, start in RUN and CHECK, valid in DONE: all ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'h80000000;
        for (int c = 0; c < 3; c++) tick();
        resp_valid = 1'b0;
        chk("idle_count", count, 0);
        chk("idle_sig",   signature, 0);
        chk("idle_state", dbg_state, 0);
        chk("idle_ready", resp_ready, 0);
        start_run(16'd2, 32'h04C11DB7);
        send_beat(32'h80000000);
        start = 1'b1;
        num_patterns = 16'd5;
        tick();
        start = 1'b0;
        chk("run_start_state", dbg_state, 1);
        chk("run_start_count", count, 1);
        chk("run_start_sig",   signature, 32'h80000000);
        send_beat(32'h00000000);
        chk("chk_state", dbg_state, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("chk_start_done", done, 1);
        chk("chk_start_state", dbg_state, 3);
        resp_valid = 1'b1;
        resp_data  = 32'h12345678;
        for (int c = 0; c < 3; c++) tick();
        resp_valid = 1'b0;
        chk("done_hold_count", count, 2);
        chk("done_hold_sig",   signature, 32'h04C11DB7);
        chk("done_hold_pass",  pass, 1);
        chk("done_hold_done",  done, 1);
        chk("done_hold_ready", resp_ready, 0);

        // restart from DONE clears done/pass on the next edge
        start_run(16'd1, 32'h00000000);
        chk("restart_pass", pass, 0);
        send_beat(32'h00000001);
        wait_done();
        chk("restart_sig",  signature, 32'h00000001);
        chk("restart_fail", pass, 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
        $finish;
    end

endmodule
